// File: rtl/parallel_serial_tx.sv
// Byte-to-bit serializer, MSB first: COM training burst, then data/idle symbols every 8 cycles.
// Optional periodic COM (SKP) insertion in ACTIVE when PS_SKP_INSERT_EN is defined.
module parallel_serial_tx #(
    parameter logic [7:0]  COM_SYM      = 8'hBC,
    parameter logic [7:0]  IDLE_SYM     = 8'hBC,
    parameter int unsigned COM_COUNT    = 4
`ifdef PS_SKP_INSERT_EN
    ,
    parameter int unsigned SKP_INTERVAL = 16
`endif
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       sym_start,
    output logic       tx_active
);

    localparam int unsigned SYM_W = 8;
    localparam int unsigned BIT_W = 3;
    localparam int unsigned COM_W = $clog2(COM_COUNT + 1);
`ifdef PS_SKP_INSERT_EN
    localparam int unsigned SKP_W = $clog2(SKP_INTERVAL + 1);
`endif

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [BIT_W-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
    logic [SYM_W-1:0]   r_shreg,     w_shreg_nxt;
    logic [SYM_W-1:0]   r_hold,      w_hold_nxt;
    logic               r_hold_full, w_hold_full_nxt;
    logic [COM_W-1:0]   r_com_cnt,   w_com_cnt_nxt;
    logic               r_data_out,  w_data_out_nxt;
    logic               r_sym_start, w_sym_start_nxt;
    logic               r_tx_active, w_tx_active_nxt;
`ifdef PS_SKP_INSERT_EN
    logic [SKP_W-1:0]   r_skp_cnt,   w_skp_cnt_nxt;
    logic               w_skp_now;
`endif
    logic [SYM_W-1:0]   w_sym;
    logic               w_load;
    logic               w_accept;

    assign w_load = (r_bit_cnt == BIT_W'(0));

`ifdef PS_SKP_INSERT_EN
    assign w_skp_now = (r_state == ACTIVE) && w_load &&
                       (r_skp_cnt == SKP_W'(SKP_INTERVAL - 1));
    // A forced COM slot keeps the held byte, so nothing new can be taken in.
    assign ready_out = (r_state == ACTIVE) && !w_skp_now && (!r_hold_full || w_load);
`else
    assign ready_out = (r_state == ACTIVE) && (!r_hold_full || w_load);
`endif

    assign w_accept  = valid_in && ready_out;
    assign data_out  = r_data_out;
    assign sym_start = r_sym_start;
    assign tx_active = r_tx_active;

    // State and datapath registers
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state     <= TRAIN;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_com_cnt   <= '0;
            r_data_out  <= 1'b0;
            r_sym_start <= 1'b0;
            r_tx_active <= 1'b0;
`ifdef PS_SKP_INSERT_EN
            r_skp_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_com_cnt   <= w_com_cnt_nxt;
            r_data_out  <= w_data_out_nxt;
            r_sym_start <= w_sym_start_nxt;
            r_tx_active <= w_tx_active_nxt;
`ifdef PS_SKP_INSERT_EN
            r_skp_cnt   <= w_skp_cnt_nxt;
`endif
        end
    end

    // Next-state: symbol selection at bit_cnt==0, shifting otherwise, hold accept
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt + BIT_W'(1);
        w_shreg_nxt     = {r_shreg[SYM_W-2:0], 1'b0};
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_com_cnt_nxt   = r_com_cnt;
        w_data_out_nxt  = r_shreg[SYM_W-1];
        w_sym_start_nxt = 1'b0;
        w_tx_active_nxt = r_tx_active;
        w_sym           = IDLE_SYM;
`ifdef PS_SKP_INSERT_EN
        w_skp_cnt_nxt   = r_skp_cnt;
`endif

        if (w_load) begin
            if (r_state == TRAIN) begin
                w_sym         = COM_SYM;
                w_com_cnt_nxt = r_com_cnt + COM_W'(1);
                if (r_com_cnt == COM_W'(COM_COUNT - 1)) begin
                    w_state_nxt     = ACTIVE;
                    w_tx_active_nxt = 1'b1;
                end
            end else begin
`ifdef PS_SKP_INSERT_EN
                w_skp_cnt_nxt = r_skp_cnt + SKP_W'(1);
                if (w_skp_now) begin
                    w_sym         = COM_SYM;
                    w_skp_cnt_nxt = '0;
                end else
`endif
                if (r_hold_full) begin
                    w_sym           = r_hold;
                    w_hold_full_nxt = 1'b0;
                end else begin
                    w_sym           = IDLE_SYM;
                end
            end
            w_data_out_nxt  = w_sym[SYM_W-1];
            w_shreg_nxt     = {w_sym[SYM_W-2:0], 1'b0};
            w_sym_start_nxt = 1'b1;
        end

        // Accept after drain so a same-edge drain+accept leaves the hold full
        if (w_accept) begin
            w_hold_nxt      = data_in;
            w_hold_full_nxt = 1'b1;
        end
    end

endmodule

// File: doc/parallel_serial_tx.md
# parallel_serial_tx

Transmit-side byte-to-bit serializer for the PCIe PHY lane; it is the upstream partner of the serial-to-parallel receiver. It takes bytes through a valid/ready handshake and shifts them out MSB-first at one bit per `clk_32f` cycle. It first sends a training burst of COM symbols (8'hBC) so the receiver can align and raise its valid. Afterwards it fills every symbol slot with either user data or an idle symbol.

## Interface
- `COM_SYM`, 8'hBC: COM symbol sent during training and for SKP insertion.
- `IDLE_SYM`, 8'hBC: symbol sent in ACTIVE when no data byte is held.
- `COM_COUNT`, 4: number of COM symbols in the training burst (≥1).
- `SKP_INTERVAL`, 16: symbol period of forced COM insertion (only with `PS_SKP_INSERT_EN`).

Ports:
- `clk_32f`  input  1  bit clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in`  input  8  byte to transmit.
- `valid_in`  input  1  `data_in` is valid.
- `ready_out`  output  1  byte accepted on an edge where `valid_in && ready_out`.
- `data_out`  output  1  serial bit, MSB first.
- `sym_start`  output  1  high while `data_out` carries bit 7 of a symbol.
- `tx_active`  output  1  high once training is done (state ACTIVE).

## Operation
- Reset (async, immediate, also mid-symbol) clears everything:
  - `data_out`=0, `sym_start`=0, `tx_active`=0.
  - bit_cnt=0, shreg=0, hold empty, com_cnt=0, skp_cnt=0.
  - state=TRAIN.
- States: TRAIN → ACTIVE. There are no other transitions except reset back to TRAIN.
- Every edge advances bit_cnt as 3-bit wrap 0..7.
- At bit_cnt==0 (symbol load):
  - sym is selected (see below).
  - `data_out`<=sym[7], shreg<=sym<<1, `sym_start`<=1.
- At other bit_cnt values:
  - `data_out`<=shreg[7], shreg<=shreg<<1, `sym_start`<=0.
- Symbol selection:
  - TRAIN: sym=`COM_SYM` and com_cnt++. When the load has com_cnt==`COM_COUNT`-1, state<=ACTIVE and `tx_active`<=1 on that same edge.
  - ACTIVE, hold full: sym=hold byte; hold is marked empty.
  - ACTIVE, hold empty: sym=`IDLE_SYM`.
- Holding register:
  - One byte deep.
  - `ready_out` = (state==ACTIVE) && (!hold_full || bit_cnt==0). This is combinational from registered state.
  - Simultaneous drain and accept at bit_cnt==0: the held byte goes to shreg, the new byte goes to hold, and hold stays full.
  - In TRAIN `ready_out`=0; `valid_in` is ignored.
- Bytes are never dropped or duplicated. Each accepted byte is sent exactly once, in acceptance order.

## Timing
- One symbol = 8 `clk_32f` cycles. The symbol boundary is fixed at bit_cnt==0 and is not realigned by traffic.
- First edge after reset release: `data_out`=1 (bit 7 of 8'hBC) and `sym_start`=1.
- Training occupies exactly 8·`COM_COUNT` cycles. The first data/idle bit 7 appears on edge 8·`COM_COUNT`+1.
- Load latency, from acceptance with hold empty to bit 7 on `data_out`: 1 to 8 edges, set by the next bit_cnt==0 edge.
- Sustained throughput is 1 byte per 8 cycles. `ready_out` is low for at most 7 consecutive cycles while hold is full.

## Configuration
- `PS_SKP_INSERT_EN` defined:
  - skp_cnt counts symbol loads in ACTIVE.
  - On the load where skp_cnt==`SKP_INTERVAL`-1, sym=`COM_SYM` regardless of hold, and skp_cnt is zeroed.
  - The hold keeps its byte, and `ready_out` stays low on that edge even at bit_cnt==0.
- Not defined: no skp_cnt logic, and the ACTIVE selection is only hold/idle.

## Test plan
- Reset release, `COM_COUNT`=4, `valid_in`=0: 32 cycles of 10111100 ×4, then idle 10111100. `tx_active` rises on the 25th edge, `sym_start` every 8th edge, `ready_out` first high after that edge.
- Single byte 8'hAA offered when `ready_out` first rises: the next symbol on `data_out` is 10101010, followed by idle BC.
- Back-to-back stream AA, BB, CC, DD, EE, FF, 00 with `valid_in` held high: serial output in order with no idle gap. `ready_out` pulses once per symbol at bit_cnt==0 after hold fills.
- `reset` asserted at bit 3 of a data symbol: `data_out`=0 and `tx_active`=0 immediately with no edge needed. After release, training restarts with a full COM burst, and the interrupted byte and held byte are discarded.
- `valid_in` toggling 1-0-1 every 5 cycles: every accepted byte appears exactly once, and empty slots carry `IDLE_SYM`.
- `PS_SKP_INSERT_EN`, `SKP_INTERVAL`=4, continuous 8'hFF: every 4th ACTIVE symbol is 10111100, with no FF lost.
